// File: rtl/argum_pkg.sv
// Shared widths and types for the MAC / divider datapath.
// The divider states and its iteration-counter width live here as well.
package argum;

    localparam int size          = 8;
    localparam int DATA_OUT_size = 16;
    localparam int CNT_W         = $clog2(DATA_OUT_size);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } divmod_state_t;

endpackage

// File: rtl/divmod_step.sv
// One restoring-division step: shift a dividend bit into the partial
// remainder, subtract the divisor when it fits, and emit the quotient bit.
module divmod_step #(
    parameter int W = 8
) (
    input  logic [W:0]   prem,
    input  logic         nextBit,
    input  logic [W-1:0] divisor,
    output logic [W:0]   premNew,
    output logic         qBit
);

    logic [W+1:0] shifted;

    assign shifted = {prem, nextBit};
    assign qBit    = (shifted >= {2'b00, divisor});
    // After a successful subtract the result is below the divisor, so W+1 bits hold it.
    assign premNew = qBit ? (W+1)'(shifted - {2'b00, divisor}) : shifted[W:0];

endmodule

// File: rtl/divmod_seq.sv
// Sequential restoring divider, one quotient bit per clock, valid/ready on both sides.
// Defining DIVMOD_DBG_EN adds check1/check2 ports exposing partial remainder and counter.
module divmod_seq
    import argum::*;
(
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_OUT_size-1:0] dividend,
    input  logic [size-1:0]          divisor,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_OUT_size-1:0] quotient,
    output logic [size-1:0]          remainder,
    output logic                     div_zero
`ifdef DIVMOD_DBG_EN
    ,
    output logic [DATA_OUT_size-1:0] check1,
    output logic [DATA_OUT_size-1:0] check2
`endif
);

    divmod_state_t            stateReg;
    logic [DATA_OUT_size-1:0] shiftReg;
    logic [size-1:0]          divisorReg;
    logic [size:0]            premReg;
    logic [CNT_W-1:0]         cntReg;
    logic                     inReadyReg;
    logic                     outValidReg;
    logic [DATA_OUT_size-1:0] quotientReg;
    logic [size-1:0]          remainderReg;
    logic                     divZeroReg;

    logic [size:0]            premNew;
    logic                     qBit;

    divmod_step #(
        .W (size)
    ) stepInst (
        .prem    (premReg),
        .nextBit (shiftReg[DATA_OUT_size-1]),
        .divisor (divisorReg),
        .premNew (premNew),
        .qBit    (qBit)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stateReg     <= IDLE;
            shiftReg     <= '0;
            divisorReg   <= '0;
            premReg      <= '0;
            cntReg       <= '0;
            inReadyReg   <= 1'b1;
            outValidReg  <= 1'b0;
            quotientReg  <= '0;
            remainderReg <= '0;
            divZeroReg   <= 1'b0;
        end else begin
            case (stateReg)
                IDLE: begin
                    if (in_valid) begin
                        shiftReg   <= dividend;
                        divisorReg <= divisor;
                        premReg    <= '0;
                        cntReg     <= CNT_W'(DATA_OUT_size - 1);
                        inReadyReg <= 1'b0;
                        if (divisor == '0) begin
                            stateReg     <= DONE;
                            outValidReg  <= 1'b1;
                            quotientReg  <= '1;
                            remainderReg <= dividend[size-1:0];
                            divZeroReg   <= 1'b1;
                        end else begin
                            stateReg <= CALC;
                        end
                    end
                end
                CALC: begin
                    // Dividend bits leave at the top while quotient bits enter at the bottom.
                    premReg  <= premNew;
                    shiftReg <= {shiftReg[DATA_OUT_size-2:0], qBit};
                    if (cntReg == '0) begin
                        stateReg     <= DONE;
                        outValidReg  <= 1'b1;
                        quotientReg  <= {shiftReg[DATA_OUT_size-2:0], qBit};
                        remainderReg <= size'(premNew);
                        divZeroReg   <= 1'b0;
                    end else begin
                        cntReg <= cntReg - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        stateReg    <= IDLE;
                        outValidReg <= 1'b0;
                        inReadyReg  <= 1'b1;
                    end
                end
                default: stateReg <= IDLE;
            endcase
        end
    end

    assign in_ready  = inReadyReg;
    assign out_valid = outValidReg;
    assign quotient  = quotientReg;
    assign remainder = remainderReg;
    assign div_zero  = divZeroReg;

`ifdef DIVMOD_DBG_EN
    assign check1 = DATA_OUT_size'(premReg);
    assign check2 = DATA_OUT_size'(cntReg);
`endif

endmodule

// File: tb/tb_divmod_seq.sv
// Directed and randomized checks of divmod_seq: results, latency, backpressure, async reset.
// With DIVMOD_DBG_EN defined, the debug counter sequence is checked too.
module tb_divmod_seq;
    import argum::*;

    logic                     clock = 1'b0;
    logic                     reset_n = 1'b0;
    logic                     in_valid = 1'b0;
    logic                     in_ready;
    logic [DATA_OUT_size-1:0] dividend = '0;
    logic [size-1:0]          divisor = '0;
    logic                     out_valid;
    logic                     out_ready = 1'b0;
    logic [DATA_OUT_size-1:0] quotient;
    logic [size-1:0]          remainder;
    logic                     div_zero;
`ifdef DIVMOD_DBG_EN
    logic [DATA_OUT_size-1:0] check1;
    logic [DATA_OUT_size-1:0] check2;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    divmod_seq dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
`ifdef DIVMOD_DBG_EN
        ,
        .check1    (check1),
        .check2    (check2)
`endif
    );

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present an operand pair; returns just after the accept edge.
    task automatic startOp(input logic [15:0] dvd, input logic [7:0] dsr);
        in_valid = 1'b1;
        dividend = dvd;
        divisor  = dsr;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    // Latency counts rising edges including the accept edge until out_valid is seen.
    task automatic waitResult(input string tag, input int startLat, input logic [15:0] expQ,
                              input logic [7:0] expR, input logic expDz, input int expLat);
        int lat = startLat;
        while (!out_valid && lat < 40) begin
            @(posedge clock);
            #1;
            lat++;
        end
        checkVal({tag, " latency"}, lat, expLat);
        checkVal({tag, " quotient"}, quotient, expQ);
        checkVal({tag, " remainder"}, remainder, expR);
        checkVal({tag, " div_zero"}, div_zero, expDz);
        $display("op %s: %0d / %0d -> q=%0d r=%0d dz=%0b lat=%0d", tag, dividend, divisor,
                 quotient, remainder, div_zero, lat);
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        checkVal({tag, " drain out_valid"}, out_valid, 0);
        checkVal({tag, " drain in_ready"}, in_ready, 1);
    endtask

    task automatic runOp(input string tag, input logic [15:0] dvd, input logic [7:0] dsr,
                         input logic [15:0] expQ, input logic [7:0] expR, input logic expDz);
        startOp(dvd, dsr);
        waitResult(tag, 1, expQ, expR, expDz, expDz ? 1 : 17);
        drain(tag);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        #22;
        checkVal("reset in_ready", in_ready, 1);
        checkVal("reset out_valid", out_valid, 0);
        checkVal("reset quotient", quotient, 0);
        checkVal("reset remainder", remainder, 0);
        checkVal("reset div_zero", div_zero, 0);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // 200*150+99, then five cycles of backpressure
        startOp(16'd30099, 8'd150);
        waitResult("30099/150", 1, 16'd200, 8'd99, 1'b0, 17);
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            #1;
            checkVal("bp out_valid", out_valid, 1);
            checkVal("bp in_ready", in_ready, 0);
            checkVal("bp quotient", quotient, 200);
            checkVal("bp remainder", remainder, 99);
        end
        // Release and present the next pair in the same cycle: not taken on the transfer edge
        out_ready = 1'b1;
        in_valid  = 1'b1;
        dividend  = 16'd65535;
        divisor   = 8'd255;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        checkVal("xfer out_valid", out_valid, 0);
        checkVal("xfer in_ready", in_ready, 1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        checkVal("accept in_ready", in_ready, 0);
        waitResult("65535/255", 1, 16'd257, 8'd0, 1'b0, 17);
        drain("65535/255");

        runOp("7/9", 16'd7, 8'd9, 16'd0, 8'd7, 1'b0);
        runOp("1234/0", 16'd1234, 8'd0, 16'hFFFF, 8'hD2, 1'b1);
        runOp("0/5", 16'd0, 8'd5, 16'd0, 8'd0, 1'b0);
        runOp("1234/1", 16'd1234, 8'd1, 16'd1234, 8'd0, 1'b0);

        // Asynchronous reset in the middle of CALC
        startOp(16'd50000, 8'd3);
        repeat (7) @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        checkVal("midreset out_valid", out_valid, 0);
        checkVal("midreset in_ready", in_ready, 1);
        checkVal("midreset quotient", quotient, 0);
        #3;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        runOp("100/7", 16'd100, 8'd7, 16'd14, 8'd2, 1'b0);

`ifdef DIVMOD_DBG_EN
        startOp(16'd1000, 8'd3);
        checkVal("dbg check1 start", check1, 0);
        for (int i = 15; i >= 0; i--) begin
            checkVal("dbg check2", check2, i);
            if (i > 0) begin
                @(posedge clock);
                #1;
            end
        end
        waitResult("dbg 1000/3", 16, 16'd333, 8'd1, 1'b0, 17);
        drain("dbg");
`endif

        for (int n = 0; n < 1000; n++) begin
            logic [15:0] dvd;
            logic [7:0]  dsr;
            logic [15:0] eq;
            logic [7:0]  er;
            dvd = 16'($urandom);
            dsr = 8'($urandom_range(0, 255));
            if (dsr == 0) begin
                eq = 16'hFFFF;
                er = dvd[7:0];
            end else begin
                eq = dvd / 16'(dsr);
                er = 8'(dvd % 16'(dsr));
            end
            runOp("rand", dvd, dsr, eq, er, dsr == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
